frame_scanout_reader: RTL and testbench

Parametrised successor to the single-buffer frame reader in the display path. Streams frames from SDRAM into the pixel FIFO in read bursts, paced by FIFO fill level. Adds multi-buffer scan-out with frame-synchronous buffer swap, configurable geometry, burst length and priming depth. Sits on the MEM_CLK domain between the SDRAM controller and the dual-clock pixel FIFO.

---
 rtl/frame_scanout_reader.sv | 155 +++++++++++++++
 tb/tb_frame_scanout_reader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/frame_scanout_reader.sv
// Purpose: stream frames from SDRAM into the pixel FIFO in fixed-length read bursts across up to four
//          buffers, swapping the scanned buffer only at frame boundaries.
// Latency: the read command and address are registered one cycle after the FIFO has room. o_FIFO_Wr
//          follows i_Data_Read_Valid in the same cycle.
// Backpressure: a burst is requested only while used + READ_BURST_LENGTH <= FIFO_HIGH_WATER. The
//          controller paces delivery with i_Data_Read_Valid.
// Ports: i_Clk / i_Reset (synchronous, active-high); i_SDRAM_Ready; i_Data_Read_Valid; i_Pixel_In_Used;
//        i_Swap_Request / i_Swap_Index; o_Command / o_Data_Address to the controller; o_FIFO_Wr;
//        o_First_Data_Ready; o_Active_Buffer; o_Frame_Done.
// Option: define SCANOUT_LOW_WATER_COUNT_EN to add the o_Low_Water_Count underrun-risk counter.
module frame_scanout_reader #(
  parameter int ADDR_WIDTH        = 22,
  parameter int FRAME_WIDTH       = 800,
  parameter int FRAME_HEIGHT      = 480,
  parameter int PIXELS_PER_WORD   = 4,
  parameter int READ_BURST_LENGTH = 8,
  parameter int NUM_BUFFERS       = 2,
  parameter logic [ADDR_WIDTH-1:0] BUFFER_STRIDE = ADDR_WIDTH'('h040000),
  parameter int FIFO_USED_WIDTH   = 10,
  parameter int FIFO_HIGH_WATER   = 512,
  parameter int PRIME_BURSTS      = 4,
  parameter logic [1:0] CMD_IDLE  = 2'd0,
  parameter logic [1:0] CMD_READ  = 2'd2
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_SDRAM_Ready,
  input  logic                       i_Data_Read_Valid,
  input  logic [FIFO_USED_WIDTH-1:0] i_Pixel_In_Used,
  input  logic                       i_Swap_Request,
  input  logic [1:0]                 i_Swap_Index,
  output logic [1:0]                 o_Command,
  output logic [ADDR_WIDTH-1:0]      o_Data_Address,
  output logic                       o_FIFO_Wr,
  output logic                       o_First_Data_Ready,
  output logic [1:0]                 o_Active_Buffer,
  output logic                       o_Frame_Done
`ifdef SCANOUT_LOW_WATER_COUNT_EN
  ,
  output logic [15:0]                o_Low_Water_Count
`endif
);

  localparam int WORDS_PER_FRAME = FRAME_WIDTH * FRAME_HEIGHT / PIXELS_PER_WORD;
  localparam int BCW = $clog2(READ_BURST_LENGTH + 1);
  localparam int PCW = $clog2(PRIME_BURSTS + 1);
  localparam int UW  = FIFO_USED_WIDTH + 1;

  typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE, BURST} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [BCW-1:0]          word_cnt;
  logic [PCW-1:0]          burst_cnt;
  logic                    swap_pending;
  logic [1:0]              swap_idx;

  logic                    room;
  logic                    last_word;
  logic                    frame_wrap;
  logic [ADDR_WIDTH-1:0]   next_offset;
  logic [ADDR_WIDTH-1:0]   buf_base;
  logic [2:0]              req_ext;
  logic [1:0]              req_idx;

  // The sum is formed one bit wider so that a nearly full FIFO cannot wrap and look empty.
  assign room = ({1'b0, i_Pixel_In_Used} + UW'(READ_BURST_LENGTH)) <= UW'(FIFO_HIGH_WATER);

  // Reset blocks forwarding at once, so controller words still in flight never reach the FIFO.
  assign o_FIFO_Wr   = !i_Reset && i_Data_Read_Valid && (state == ISSUE || state == BURST);
  assign last_word   = o_FIFO_Wr && (word_cnt == BCW'(READ_BURST_LENGTH - 1));
  assign next_offset = offset + ADDR_WIDTH'(READ_BURST_LENGTH);
  assign frame_wrap  = last_word && (next_offset == ADDR_WIDTH'(WORDS_PER_FRAME));
  assign buf_base    = ADDR_WIDTH'(o_Active_Buffer) * BUFFER_STRIDE;
  assign req_ext     = {1'b0, i_Swap_Index} % 3'(NUM_BUFFERS);
  assign req_idx     = req_ext[1:0];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state              <= WAIT_INIT;
      offset             <= '0;
      word_cnt           <= '0;
      burst_cnt          <= '0;
      swap_pending       <= 1'b0;
      swap_idx           <= 2'd0;
      o_Command          <= CMD_IDLE;
      o_Data_Address     <= '0;
      o_First_Data_Ready <= 1'b0;
      o_Active_Buffer    <= 2'd0;
      o_Frame_Done       <= 1'b0;
    end else begin
      o_Frame_Done <= 1'b0;

      // The buffer changes only at a wrap. A request that arrives in the wrap cycle takes
      // precedence over an older pending request.
      if (frame_wrap) begin
        if (i_Swap_Request)
          o_Active_Buffer <= req_idx;
        else if (swap_pending)
          o_Active_Buffer <= swap_idx;
        swap_pending <= 1'b0;
      end else if (i_Swap_Request) begin
        swap_pending <= 1'b1;
        swap_idx     <= req_idx;
      end

      case (state)
        WAIT_INIT: begin
          if (i_SDRAM_Ready)
            state <= IDLE;
        end
        IDLE: begin
          if (room) begin
            state          <= ISSUE;
            o_Command      <= CMD_READ;
            o_Data_Address <= buf_base + offset;
            word_cnt       <= '0;
          end
        end
        ISSUE, BURST: begin
          if (o_FIFO_Wr) begin
            o_Command <= CMD_IDLE;
            if (last_word) begin
              state        <= IDLE;
              word_cnt     <= '0;
              offset       <= frame_wrap ? '0 : next_offset;
              o_Frame_Done <= frame_wrap;
              if (!o_First_Data_Ready) begin
                burst_cnt <= burst_cnt + PCW'(1);
                if ((burst_cnt + PCW'(1)) == PCW'(PRIME_BURSTS))
                  o_First_Data_Ready <= 1'b1;
              end
            end else begin
              state    <= BURST;
              word_cnt <= word_cnt + BCW'(1);
            end
          end
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

`ifdef SCANOUT_LOW_WATER_COUNT_EN
  // Counts the cycles in which video is running and the FIFO holds less than one burst.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      o_Low_Water_Count <= 16'd0;
    else if (o_First_Data_Ready && (i_Pixel_In_Used < FIFO_USED_WIDTH'(READ_BURST_LENGTH))
             && (o_Low_Water_Count != 16'hFFFF))
      o_Low_Water_Count <= o_Low_Water_Count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Purpose: check frame_scanout_reader in a small 8x2-pixel configuration against a hand-computed
//          cycle-by-cycle trace.
// Method: drive inputs at each negedge and compare every output 1 ns later, before the next posedge.
module tb_frame_scanout_reader;

  localparam logic [21:0] B1 = 22'h040000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        vld;
  logic [9:0]  used;
  logic        sq;
  logic [1:0]  si;
  logic [1:0]  cmd;
  logic [21:0] addr;
  logic        wr;
  logic        fdr;
  logic [1:0]  act;
  logic        done;
`ifdef SCANOUT_LOW_WATER_COUNT_EN
  logic [15:0] lwc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_scanout_reader #(
    .ADDR_WIDTH(22), .FRAME_WIDTH(8), .FRAME_HEIGHT(2), .PIXELS_PER_WORD(4),
    .READ_BURST_LENGTH(2), .NUM_BUFFERS(2), .FIFO_USED_WIDTH(10),
    .FIFO_HIGH_WATER(8), .PRIME_BURSTS(1)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_SDRAM_Ready(rdy),
    .i_Data_Read_Valid(vld),
    .i_Pixel_In_Used(used),
    .i_Swap_Request(sq),
    .i_Swap_Index(si),
    .o_Command(cmd),
    .o_Data_Address(addr),
    .o_FIFO_Wr(wr),
    .o_First_Data_Ready(fdr),
    .o_Active_Buffer(act),
    .o_Frame_Done(done)
`ifdef SCANOUT_LOW_WATER_COUNT_EN
    ,
    .o_Low_Water_Count(lwc)
`endif
  );

  typedef struct {
    logic        rst, rdy, vld;
    logic [9:0]  used;
    logic        sq;
    logic [1:0]  si;
    logic [1:0]  cmd;
    logic [21:0] addr;
    logic        wr, fdr;
    logic [1:0]  act;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic y, input logic v, input logic [9:0] u,
                     input logic q, input logic [1:0] i, input logic [1:0] c,
                     input logic [21:0] a, input logic w, input logic f,
                     input logic [1:0] b, input logic d);
    vec_t e;
    e.rst = r; e.rdy = y; e.vld = v; e.used = u; e.sq = q; e.si = i;
    e.cmd = c; e.addr = a; e.wr = w; e.fdr = f; e.act = b; e.done = d;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [1:0] c, input logic [21:0] a,
                     input logic w, input logic f, input logic [1:0] b, input logic d);
    checks++;
    if (cmd !== c || addr !== a || wr !== w || fdr !== f || act !== b || done !== d) begin
      errors++;
      $display("FAIL %s: got cmd=%0d addr=%h wr=%b fdr=%b act=%0d done=%b, want cmd=%0d addr=%h wr=%b fdr=%b act=%0d done=%b",
               name, cmd, addr, wr, fdr, act, done, c, a, w, f, b, d);
    end
  endtask

  initial begin
    // Each row lists rst rdy vld used sq si, then the expected cmd addr wr fdr act done.
    add(0,1,0,0,0,0, 0,0,0,0,0,0);        // still in WAIT_INIT; ready is sampled at this edge
    add(0,1,0,0,0,0, 0,0,0,0,0,0);        // IDLE with room
    add(0,1,0,0,0,0, 2,0,0,0,0,0);        // ISSUE at address 0
    add(0,1,0,0,0,0, 2,0,0,0,0,0);
    add(0,1,0,0,0,0, 2,0,0,0,0,0);        // command held until the first valid
    add(0,1,1,0,0,0, 2,0,1,0,0,0);        // first word
    add(0,1,1,0,0,0, 0,0,1,0,0,0);        // second word ends the burst
    add(0,1,0,7,0,0, 0,0,0,1,0,0);        // primed; 7+2>8 keeps the FSM in IDLE
    add(0,1,1,7,0,0, 0,0,0,1,0,0);        // a stray valid in IDLE is dropped
    add(0,1,0,6,1,1, 0,0,0,1,0,0);        // 6+2<=8; swap to buffer 1 requested
    add(0,1,0,0,0,0, 2,2,0,1,0,0);        // second burst still on buffer 0, at address 2
    add(0,1,1,0,0,0, 2,2,1,1,0,0);
    add(0,1,1,0,0,0, 0,2,1,1,0,0);        // last word of the frame
    add(0,1,0,0,0,0, 0,2,0,1,1,1);        // frame-done pulse; buffer 1 active
    add(0,1,0,0,0,0, 2,B1,0,1,1,0);       // burst at 0x040000
    add(0,1,1,0,1,0, 2,B1,1,1,1,0);       // request index 0 ...
    add(0,1,1,0,1,3, 0,B1,1,1,1,0);       // ... overwritten by index 3 (mod 2 gives 1)
    add(0,1,0,0,0,0, 0,B1,0,1,1,0);
    add(0,1,1,0,0,0, 2,B1+22'd2,1,1,1,0);
    add(0,1,1,0,0,0, 0,B1+22'd2,1,1,1,0); // wrap; pending index 1 leaves buffer 1 active
    add(0,1,0,8,0,0, 0,B1+22'd2,0,1,1,1); // 8+2>8 keeps the FSM in IDLE
    add(0,1,0,0,0,0, 0,B1+22'd2,0,1,1,0);
    add(0,1,1,0,0,0, 2,B1,1,1,1,0);
    add(0,1,1,0,0,0, 0,B1,1,1,1,0);
    add(0,1,0,0,0,0, 0,B1,0,1,1,0);
    add(0,1,1,0,0,0, 2,B1+22'd2,1,1,1,0);
    add(0,1,1,0,1,0, 0,B1+22'd2,1,1,1,0); // request coincides with the last valid of the frame
    add(0,1,0,0,0,0, 0,B1+22'd2,0,1,0,1); // applied at that wrap: buffer 0
    add(0,1,0,0,0,0, 2,0,0,1,0,0);
    add(0,1,1,0,0,0, 2,0,1,1,0,0);        // first word of the burst
    add(1,1,1,0,0,0, 0,0,0,1,0,0);        // reset mid-burst blocks the FIFO write at once
    add(0,1,1,0,0,0, 0,0,0,0,0,0);        // all outputs at reset values; residual valid dropped
    add(0,1,1,0,0,0, 0,0,0,0,0,0);        // IDLE; valid still dropped
    add(0,1,0,0,0,0, 2,0,0,0,0,0);        // restarts at buffer 0, offset 0

    rst = 1'b1; rdy = 1'b0; vld = 1'b0; used = '0; sq = 1'b0; si = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("reset", 0, 0, 0, 0, 0, 0);

    // Controller not yet initialised: no command and no writes, even with valids present.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vld = k[0];
      #1 chk($sformatf("wait_init%0d", k), 0, 0, 0, 0, 0, 0);
    end

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      rst = vecs[n].rst; rdy = vecs[n].rdy; vld = vecs[n].vld;
      used = vecs[n].used; sq = vecs[n].sq; si = vecs[n].si;
      #1 chk($sformatf("vec%0d", n), vecs[n].cmd, vecs[n].addr, vecs[n].wr,
             vecs[n].fdr, vecs[n].act, vecs[n].done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
